// File: rtl/instr_fetch_if.sv
// Handshake bundle between the fetch controller, instruction memory,
// the prefetch buffer and the core's branch logic.
interface instr_fetch_if;
  logic        fetch_enable_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        pf_write_en_o;
  logic [31:0] pf_data_o;
  logic        pf_flush_o;
  logic        pf_skip_o;
  logic [1:0]  pf_read_en_i;
  logic [3:0]  pf_hw_count_o;

  modport master (
    input  fetch_enable_i, branch_i, branch_target_i,
           instr_gnt_i, instr_rvalid_i, instr_rdata_i, pf_read_en_i,
    output instr_req_o, instr_addr_o,
           pf_write_en_o, pf_data_o, pf_flush_o, pf_skip_o, pf_hw_count_o
  );

  modport slave (
    output fetch_enable_i, branch_i, branch_target_i,
           instr_gnt_i, instr_rvalid_i, instr_rdata_i, pf_read_en_i,
    input  instr_req_o, instr_addr_o,
           pf_write_en_o, pf_data_o, pf_flush_o, pf_skip_o, pf_hw_count_o
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction-fetch controller: issues word fetches only when the prefetch
// buffer has a guaranteed slot for every in-flight response; handles redirects.
module instr_fetch_ctrl #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] BOOT_ADDR       = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, RUN, REDIRECT} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   tgt_q, tgt_d;
  logic          req_q, req_d;
  logic [3:0]    hw_cnt_q, hw_cnt_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] drop_cnt_q, drop_cnt_d;
  logic          skip_pending_q, skip_pending_d;

  logic          gnt_fire;
  logic          stale_pending;
  logic          drop_hit;
  logic          write_en;
  logic [4:0]    rd_hw;
  logic [4:0]    wr_hw;
  logic [4:0]    hw_sum;
  logic [7:0]    need;
  logic          unused_target_bit0;

  assign gnt_fire      = req_q & bus.instr_gnt_i;
  assign stale_pending = req_q & ~bus.instr_gnt_i;
  assign drop_hit      = bus.instr_rvalid_i & (drop_cnt_q != '0);
  // Data returning in the flush cycle belongs to the old stream.
  assign write_en      = bus.instr_rvalid_i & ~drop_hit & ~bus.branch_i;

  assign unused_target_bit0 = bus.branch_target_i[0];

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    rd_hw = 5'd0;
    case (bus.pf_read_en_i)
      2'b10:   rd_hw = 5'd1;
      2'b11:   rd_hw = 5'd2;
      default: rd_hw = 5'd0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    tgt_d          = tgt_q;
    skip_pending_d = skip_pending_q;
    outstanding_d  = outstanding_q + OW'(gnt_fire) - OW'(bus.instr_rvalid_i);
    drop_cnt_d     = drop_cnt_q - OW'(drop_hit);

    wr_hw    = write_en ? (skip_pending_q ? 5'd1 : 5'd2) : 5'd0;
    hw_sum   = {1'b0, hw_cnt_q} + wr_hw;
    hw_cnt_d = (rd_hw > hw_sum) ? 4'd0 : 4'(hw_sum - rd_hw);
    if (write_en) skip_pending_d = 1'b0;

    case (state_q)
      IDLE:    if (bus.fetch_enable_i) state_d = RUN;
      RUN:     if (!bus.fetch_enable_i && !stale_pending) state_d = IDLE;
      default: ;
    endcase

    if (gnt_fire) begin
      if (state_q == REDIRECT) begin
        // The stale request finally went out: its response must be discarded.
        pc_d       = tgt_q;
        drop_cnt_d = drop_cnt_d + OW'(1);
        state_d    = bus.fetch_enable_i ? RUN : IDLE;
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end

    if (bus.branch_i) begin
      hw_cnt_d       = 4'd0;
      drop_cnt_d     = outstanding_d;
      skip_pending_d = bus.branch_target_i[1];
      if (stale_pending) begin
        state_d = REDIRECT;
        tgt_d   = {bus.branch_target_i[31:2], 2'b00};
      end else begin
        pc_d    = {bus.branch_target_i[31:2], 2'b00};
        state_d = bus.fetch_enable_i ? RUN : IDLE;
      end
    end

    // Every live (non-dropped) in-flight word plus the new one must fit.
    need  = 8'(hw_cnt_d) + ((8'(outstanding_d) - 8'(drop_cnt_d)) << 1) + 8'd2;
    req_d = stale_pending |
            ((state_d == RUN) && (need <= 8'(2 * DEPTH)) &&
             (outstanding_d < OW'(MAX_OUTSTANDING)));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      pc_q           <= {BOOT_ADDR[31:1], 1'b0};
      tgt_q          <= 32'd0;
      req_q          <= 1'b0;
      hw_cnt_q       <= 4'd0;
      outstanding_q  <= '0;
      drop_cnt_q     <= '0;
      skip_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      tgt_q          <= tgt_d;
      req_q          <= req_d;
      hw_cnt_q       <= hw_cnt_d;
      outstanding_q  <= outstanding_d;
      drop_cnt_q     <= drop_cnt_d;
      skip_pending_q <= skip_pending_d;
    end
  end

  assign bus.instr_req_o   = req_q;
  assign bus.instr_addr_o  = {pc_q[31:2], 2'b00};
  assign bus.pf_write_en_o = write_en;
  assign bus.pf_data_o     = bus.instr_rdata_i;
  assign bus.pf_flush_o    = bus.branch_i;
  assign bus.pf_skip_o     = write_en & skip_pending_q;
  assign bus.pf_hw_count_o = hw_cnt_q;

  // The decoder must never consume more halfwords than are available.
  a_no_overread: assert property (@(posedge clk) disable iff (rst)
    !(!bus.branch_i && (rd_hw > hw_sum)));

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: a table-driven fill/drain run plus
// hand-written sequences for stalls, redirects and mid-transfer reset.
module tb_instr_fetch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  instr_fetch_if bus();

  instr_fetch_ctrl #(
    .DEPTH(4), .MAX_OUTSTANDING(2), .BOOT_ADDR(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        en;
    logic        br;
    logic [31:0] tgt;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic [1:0]  rd;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic        fl;
    logic        sk;
    logic [3:0]  hw;
  } vec_t;

  function automatic vec_t mk(
    input logic en, input logic br, input logic [31:0] tgt,
    input logic gnt, input logic rv, input logic [31:0] rdata,
    input logic [1:0] rd,
    input logic req, input logic [31:0] addr, input logic we,
    input logic fl, input logic sk, input logic [3:0] hw);
    vec_t v;
    v.en = en;   v.br = br;   v.tgt = tgt;  v.gnt = gnt; v.rv = rv;
    v.rdata = rdata; v.rd = rd;
    v.req = req; v.addr = addr; v.we = we;  v.fl = fl;   v.sk = sk;
    v.hw = hw;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.fetch_enable_i  = 1'b0;
    bus.branch_i        = 1'b0;
    bus.branch_target_i = 32'd0;
    bus.instr_gnt_i     = 1'b0;
    bus.instr_rvalid_i  = 1'b0;
    bus.instr_rdata_i   = 32'd0;
    bus.pf_read_en_i    = 2'b00;
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s.req", tag),   32'(bus.instr_req_o),   32'd0);
    check($sformatf("%s.addr", tag),  bus.instr_addr_o,       32'd0);
    check($sformatf("%s.we", tag),    32'(bus.pf_write_en_o), 32'd0);
    check($sformatf("%s.flush", tag), 32'(bus.pf_flush_o),    32'd0);
    check($sformatf("%s.skip", tag),  32'(bus.pf_skip_o),     32'd0);
    check($sformatf("%s.hw", tag),    32'(bus.pf_hw_count_o), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    #2;
    check_reset_outputs(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Inputs change on the falling edge; outputs are checked 2 time units later,
  // well before the next rising edge.
  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    bus.fetch_enable_i  = v.en;
    bus.branch_i        = v.br;
    bus.branch_target_i = v.tgt;
    bus.instr_gnt_i     = v.gnt;
    bus.instr_rvalid_i  = v.rv;
    bus.instr_rdata_i   = v.rdata;
    bus.pf_read_en_i    = v.rd;
    #2;
    check($sformatf("%s.req", tag),   32'(bus.instr_req_o),   32'(v.req));
    check($sformatf("%s.addr", tag),  bus.instr_addr_o,       v.addr);
    check($sformatf("%s.we", tag),    32'(bus.pf_write_en_o), 32'(v.we));
    check($sformatf("%s.data", tag),  bus.pf_data_o,          v.rdata);
    check($sformatf("%s.flush", tag), 32'(bus.pf_flush_o),    32'(v.fl));
    check($sformatf("%s.skip", tag),  32'(bus.pf_skip_o),     32'(v.sk));
    check($sformatf("%s.hw", tag),    32'(bus.pf_hw_count_o), 32'(v.hw));
  endtask

  vec_t fill_tbl [15];

  initial begin
    drive_idle();

    //                en br tgt gnt rv rdata         rd     req addr       we fl sk hw
    fill_tbl[0]  = mk(1, 0, 0, 0, 0, 32'h0,        2'b00, 0, 32'h00, 0, 0, 0, 4'd0);
    fill_tbl[1]  = mk(1, 0, 0, 1, 0, 32'h0,        2'b00, 1, 32'h00, 0, 0, 0, 4'd0);
    fill_tbl[2]  = mk(1, 0, 0, 1, 1, 32'hD000_0000, 2'b00, 1, 32'h04, 1, 0, 0, 4'd0);
    fill_tbl[3]  = mk(1, 0, 0, 1, 1, 32'hD000_0004, 2'b00, 1, 32'h08, 1, 0, 0, 4'd2);
    fill_tbl[4]  = mk(1, 0, 0, 1, 1, 32'hD000_0008, 2'b00, 1, 32'h0C, 1, 0, 0, 4'd4);
    fill_tbl[5]  = mk(1, 0, 0, 0, 1, 32'hD000_000C, 2'b00, 0, 32'h10, 1, 0, 0, 4'd6);
    fill_tbl[6]  = mk(1, 0, 0, 0, 0, 32'h0,        2'b00, 0, 32'h10, 0, 0, 0, 4'd8);
    fill_tbl[7]  = mk(1, 0, 0, 0, 0, 32'h0,        2'b11, 0, 32'h10, 0, 0, 0, 4'd8);
    fill_tbl[8]  = mk(1, 0, 0, 0, 0, 32'h0,        2'b00, 1, 32'h10, 0, 0, 0, 4'd6);
    fill_tbl[9]  = mk(1, 0, 0, 1, 0, 32'h0,        2'b00, 1, 32'h10, 0, 0, 0, 4'd6);
    fill_tbl[10] = mk(1, 0, 0, 0, 1, 32'hD000_0010, 2'b00, 0, 32'h14, 1, 0, 0, 4'd6);
    fill_tbl[11] = mk(1, 0, 0, 0, 0, 32'h0,        2'b01, 0, 32'h14, 0, 0, 0, 4'd8);
    fill_tbl[12] = mk(1, 0, 0, 0, 0, 32'h0,        2'b10, 0, 32'h14, 0, 0, 0, 4'd8);
    fill_tbl[13] = mk(1, 0, 0, 0, 0, 32'h0,        2'b10, 0, 32'h14, 0, 0, 0, 4'd7);
    fill_tbl[14] = mk(1, 0, 0, 0, 0, 32'h0,        2'b00, 1, 32'h14, 0, 0, 0, 4'd6);

    #2;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;

    // Fill to capacity, then drain and refill one word at a time.
    for (int i = 0; i < 15; i++) step(fill_tbl[i], $sformatf("fill%0d", i));

    // Grant withheld for three cycles on 0x4.
    do_reset("rst_b");
    step(mk(1, 0, 0, 0, 0, 32'h0,  2'b00, 0, 32'h00, 0, 0, 0, 4'd0), "stall0");
    step(mk(1, 0, 0, 1, 0, 32'h0,  2'b00, 1, 32'h00, 0, 0, 0, 4'd0), "stall1");
    step(mk(1, 0, 0, 0, 1, 32'hA0, 2'b00, 1, 32'h04, 1, 0, 0, 4'd0), "stall2");
    step(mk(1, 0, 0, 0, 0, 32'h0,  2'b00, 1, 32'h04, 0, 0, 0, 4'd2), "stall3");
    step(mk(1, 0, 0, 0, 0, 32'h0,  2'b00, 1, 32'h04, 0, 0, 0, 4'd2), "stall4");
    step(mk(1, 0, 0, 1, 0, 32'h0,  2'b00, 1, 32'h04, 0, 0, 0, 4'd2), "stall5");
    step(mk(1, 0, 0, 0, 0, 32'h0,  2'b00, 1, 32'h08, 0, 0, 0, 4'd2), "stall6");

    // Branch to 0x100 with two granted requests still in flight.
    do_reset("rst_c");
    step(mk(1, 0, 0,        0, 0, 32'h0,         2'b00, 0, 32'h000, 0, 0, 0, 4'd0), "brc0");
    step(mk(1, 0, 0,        1, 0, 32'h0,         2'b00, 1, 32'h000, 0, 0, 0, 4'd0), "brc1");
    step(mk(1, 0, 0,        1, 0, 32'h0,         2'b00, 1, 32'h004, 0, 0, 0, 4'd0), "brc2");
    step(mk(1, 1, 32'h100,  0, 0, 32'h0,         2'b00, 0, 32'h008, 0, 1, 0, 4'd0), "brc3");
    step(mk(1, 0, 0,        0, 1, 32'h5AAE_0000, 2'b00, 0, 32'h100, 0, 0, 0, 4'd0), "brc4");
    step(mk(1, 0, 0,        1, 1, 32'h5AAE_0004, 2'b00, 1, 32'h100, 0, 0, 0, 4'd0), "brc5");
    step(mk(1, 0, 0,        0, 1, 32'hAAAA_0100, 2'b00, 1, 32'h104, 1, 0, 0, 4'd0), "brc6");
    step(mk(1, 0, 0,        0, 0, 32'h0,         2'b00, 1, 32'h104, 0, 0, 0, 4'd2), "brc7");

    // Halfword-aligned target 0x102, issued from IDLE before fetch is enabled.
    do_reset("rst_d");
    step(mk(0, 1, 32'h102, 0, 0, 32'h0,         2'b00, 0, 32'h000, 0, 1, 0, 4'd0), "hw0");
    step(mk(0, 0, 0,       0, 0, 32'h0,         2'b00, 0, 32'h100, 0, 0, 0, 4'd0), "hw1");
    step(mk(1, 0, 0,       0, 0, 32'h0,         2'b00, 0, 32'h100, 0, 0, 0, 4'd0), "hw2");
    step(mk(1, 0, 0,       1, 0, 32'h0,         2'b00, 1, 32'h100, 0, 0, 0, 4'd0), "hw3");
    step(mk(1, 0, 0,       0, 1, 32'h1234_5678, 2'b00, 1, 32'h104, 1, 0, 1, 4'd0), "hw4");
    step(mk(1, 0, 0,       1, 0, 32'h0,         2'b00, 1, 32'h104, 0, 0, 0, 4'd1), "hw5");
    step(mk(1, 0, 0,       0, 1, 32'h9ABC_DEF0, 2'b00, 1, 32'h108, 1, 0, 0, 4'd1), "hw6");
    step(mk(1, 0, 0,       0, 0, 32'h0,         2'b00, 1, 32'h108, 0, 0, 0, 4'd3), "hw7");

    // Branch to 0x200 while the request to 0x8 is still waiting for its grant.
    do_reset("rst_e");
    step(mk(1, 0, 0,       0, 0, 32'h0,         2'b00, 0, 32'h000, 0, 0, 0, 4'd0), "rdr0");
    step(mk(1, 0, 0,       1, 0, 32'h0,         2'b00, 1, 32'h000, 0, 0, 0, 4'd0), "rdr1");
    step(mk(1, 0, 0,       1, 1, 32'hC000_0000, 2'b00, 1, 32'h004, 1, 0, 0, 4'd0), "rdr2");
    step(mk(1, 1, 32'h200, 0, 0, 32'h0,         2'b10, 1, 32'h008, 0, 1, 0, 4'd2), "rdr3");
    step(mk(1, 0, 0,       0, 1, 32'h5AAE_0004, 2'b00, 1, 32'h008, 0, 0, 0, 4'd0), "rdr4");
    step(mk(1, 0, 0,       1, 0, 32'h0,         2'b00, 1, 32'h008, 0, 0, 0, 4'd0), "rdr5");
    step(mk(1, 0, 0,       0, 1, 32'h5AAE_0008, 2'b00, 1, 32'h200, 0, 0, 0, 4'd0), "rdr6");
    step(mk(1, 0, 0,       1, 0, 32'h0,         2'b00, 1, 32'h200, 0, 0, 0, 4'd0), "rdr7");
    step(mk(1, 0, 0,       0, 1, 32'hBBBB_0200, 2'b00, 1, 32'h204, 1, 0, 0, 4'd0), "rdr8");

    // Reset in the middle of a transfer takes effect without a clock edge.
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    step(mk(1, 0, 0, 0, 0, 32'h0, 2'b00, 0, 32'h000, 0, 0, 0, 4'd0), "restart0");
    step(mk(1, 0, 0, 0, 0, 32'h0, 2'b00, 1, 32'h000, 0, 0, 0, 4'd0), "restart1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
